// File: rtl/clause_stream_memory.sv
// Writable clause store that streams NUM_CLAUSES_PER_CYCLE-wide rows over valid/ready.
// Optional macro CLAUSE_STREAM_MASK_EN adds per-clause loaded bits, clr and out_mask tracking.
module clause_stream_memory #(
  parameter int unsigned NUM_CLAUSES           = 64,
  parameter int unsigned VAR_ID_BITS           = 8,
  parameter int unsigned NUM_CLAUSES_PER_CYCLE = 16,
  parameter int unsigned NUM_VARS_PER_CLAUSE   = 3,
  localparam int unsigned CW        = (VAR_ID_BITS + 1) * NUM_VARS_PER_CLAUSE,
  localparam int unsigned ROW_WIDTH = CW * NUM_CLAUSES_PER_CYCLE,
  localparam int unsigned NUM_ROWS  = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int unsigned PTR_BITS  = $clog2(NUM_ROWS),
  localparam int unsigned IDX_BITS  = $clog2(NUM_CLAUSES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  output logic                             wr_ready,
  input  logic [IDX_BITS-1:0]              wr_addr,
  input  logic [CW-1:0]                    wr_clause,
  input  logic                             clr,
  input  logic                             start,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PTR_BITS-1:0]              out_row,
  output logic [ROW_WIDTH-1:0]             out_data,
  output logic [NUM_CLAUSES_PER_CYCLE-1:0] out_mask,
  output logic                             done
);

  localparam int unsigned NPC       = NUM_CLAUSES_PER_CYCLE;
  localparam int unsigned LANE_BITS = $clog2(NPC);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [PTR_BITS-1:0]   out_row_q, out_row_d;
  logic [ROW_WIDTH-1:0]  out_data_q, out_data_d;
  logic [NPC-1:0]        out_mask_q, out_mask_d;

  logic [ROW_WIDTH-1:0]  mem_q [NUM_ROWS];

  logic                  addr_ok, wr_fire, start_fire, hs, last_row, load_row;
  logic [PTR_BITS-1:0]   wr_row, rd_ptr;
  logic [LANE_BITS-1:0]  wr_lane;
  logic [NPC-1:0]        rd_mask;

  assign wr_ready   = (state_q == IDLE) && !start && !clr;
  assign addr_ok    = 32'(wr_addr) < NUM_CLAUSES;
  assign wr_fire    = wr_en && wr_ready && addr_ok;
  assign wr_row     = PTR_BITS'(wr_addr / IDX_BITS'(NPC));
  assign wr_lane    = LANE_BITS'(wr_addr % IDX_BITS'(NPC));
  assign start_fire = (state_q == IDLE) && start && !clr;
  assign hs         = out_valid_q && out_ready;
  assign last_row   = out_row_q == PTR_BITS'(NUM_ROWS - 1);
  assign load_row   = start_fire || ((state_q == STREAM) && hs && !last_row);
  assign rd_ptr     = (state_q == IDLE) ? '0 : out_row_q + PTR_BITS'(1);

  // Clause storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_row][32'(wr_lane) * CW +: CW] <= wr_clause;
  end

`ifdef CLAUSE_STREAM_MASK_EN
  logic [NUM_CLAUSES-1:0] loaded_q, loaded_d;
  logic                   clr_fire;

  assign clr_fire = (state_q == IDLE) && clr;
  assign rd_mask  = loaded_q[IDX_BITS'(rd_ptr) * IDX_BITS'(NPC) +: NPC];

  always_comb begin
    loaded_d = loaded_q;
    if (clr_fire)     loaded_d = '0;
    else if (wr_fire) loaded_d[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) loaded_q <= '0;
    else     loaded_q <= loaded_d;
  end
`else
  assign rd_mask = '1;
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    case (state_q)
      IDLE: begin
        if (start_fire) begin
          state_d     = STREAM;
          out_valid_d = 1'b1;
        end
      end
      STREAM: begin
        if (hs && last_row) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_mask_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_row) begin
      out_row_d  = rd_ptr;
      out_data_d = mem_q[rd_ptr];
      out_mask_d = rd_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
    end
  end

  assign busy      = state_q == STREAM;
  assign done      = (state_q == STREAM) && hs && last_row;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;

endmodule
